apb_reg_responder: RTL and testbench
====================================

// Module: apb_reg_responder
// PURPOSE
//   APB completer (slave end) of the apb_if bus: answers paddr/pwdata/pwrite/psel/penable
//   transfers from the TB master and returns prdata/pready/pslverr. Holds NUM_REGS RW
//   registers, an RO ID register and an RO transfer counter. Flags protocol violations by
//   the requester. Serves as the DUT-side model for the APB agent's master driver.
// PARAMETERS
//   NUM_REGS     8             number of 32-bit RW registers (1..64)
//   BASE_ADDR    32'h0000_0000 byte address of register 0; must be 4-byte aligned
//   WAIT_STATES  0             access-phase wait cycles before pready (0..15)
//   ID_VALUE     32'hA5B0_0001 value returned by the ID register
// PORTS
//   clk        in   1              bus clock, all flops on posedge
//   rstn       in   1              asynchronous active-low reset
//   paddr      in   32             byte address
//   pwdata     in   32             write data
//   pwrite     in   1              1=write, 0=read
//   psel       in   1              select
//   penable    in   1              access phase
//   prdata     out  32             read data, valid when pready=1 on a read
//   pready     out  1              transfer completes this cycle
//   pslverr    out  1              error response, valid only when pready=1
//   reg_q      out  32*NUM_REGS    flat RW register contents, reg i at [32*i+:32]
//   proto_err  out  1              sticky protocol-violation flag
// BEHAVIOUR
//   Reset: all outputs 0, all RW regs 0, xfer_cnt 0, FSM IDLE, wait counter 0, proto_err 0.
//   Address map (off = paddr-BASE_ADDR): off 0x0..4*(NUM_REGS-1) RW reg[off>>2];
//     off 4*NUM_REGS ID (RO); off 4*NUM_REGS+4 XFER_CNT (RO, 32-bit, wraps to 0).
//   Decode error: paddr[1:0]!=0, paddr<BASE_ADDR, off beyond XFER_CNT, or write to RO reg
//     -> pslverr=1 at completion, no register updated, prdata=0.
//   FSM, sampled at posedge:
//     IDLE: psel=1,penable=0 -> capture paddr/pwrite/pwdata, compute err,
//       wcnt<=WAIT_STATES, go ACCESS. psel=1,penable=1 -> proto_err<=1, stay IDLE.
//     ACCESS: psel=0 or penable=0 -> abort: no write, no count, proto_err<=1, IDLE.
//       Else if wcnt!=0 -> wcnt<=wcnt-1. Else complete: commit write if !err,
//       xfer_cnt<=xfer_cnt+1 (also for error transfers), go IDLE.
//     paddr/pwrite/pwdata change during ACCESS -> proto_err<=1; captured values used.
//   pready  = (state==ACCESS && wcnt==0), decoded from flops only.
//   pslverr = pready & captured err.
//   prdata  = pready & !cap_write & !err ? mux(cap_addr) : 0. XFER_CNT reads the
//     pre-increment value.
//   Latency: WAIT_STATES=0 gives a 2-cycle transfer (SETUP+ACCESS), compatible with
//     masters that ignore pready. Otherwise 2+WAIT_STATES cycles.
//   Back-to-back: a new SETUP is accepted the cycle after completion; no dead cycle needed.
//   Write data lands in reg_q the cycle after the completion cycle.
//   proto_err clears only on reset. rstn low mid-transfer: immediate IDLE, write lost.
// TESTING
//   1 WAIT=0: write 0xDEADBEEF to BASE+0x4, read back -> pready on 2nd cycle,
//     prdata=0xDEADBEEF, pslverr=0, reg_q[63:32]=0xDEADBEEF.
//   2 Read ID (BASE+4*NUM_REGS) -> 0xA5B00001. Write 0x1 to ID -> pslverr=1, ID unchanged.
//   3 Reads at BASE+0x2 and BASE+4*NUM_REGS+8 -> pslverr=1, prdata=0.
//     XFER_CNT read afterwards = 2+prior count.
//   4 WAIT_STATES=3: write -> pready low for 3 ACCESS cycles, high on 4th; 5-cycle transfer.
//   5 Drop psel mid-ACCESS (WAIT=3) -> no write, proto_err=1. penable=1 in IDLE -> proto_err=1.
//   6 Assert rstn=0 mid-ACCESS -> outputs and regs 0 asynchronously.
//     Preset XFER_CNT 0xFFFFFFFF via 2^32 model force -> wraps to 0.

Source files
------------

// File: rtl/apb_reg_responder.sv
`default_nettype none
// ============================================================================
// Module   : apb_reg_responder
// Purpose  : APB completer with NUM_REGS read/write registers, a read-only ID
//            register and a read-only completed-transfer counter. It flags
//            requester protocol violations in a sticky bit.
// Ports    : clk, rstn             - bus clock, async active-low reset
//            paddr/pwdata/pwrite   - request address, write data, direction
//            psel/penable          - APB select / access-phase strobe
//            prdata/pready/pslverr - completion response
//            reg_q                 - flat RW register contents, reg i at [32*i+:32]
//            proto_err             - sticky protocol-violation flag
// Revision : 1.0 - initial release
// ============================================================================
module apb_reg_responder #(
  parameter int          NUM_REGS    = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [31:0]              paddr,
  input  logic [31:0]              pwdata,
  input  logic                     pwrite,
  input  logic                     psel,
  input  logic                     penable,
  output logic [31:0]              prdata,
  output logic                     pready,
  output logic                     pslverr,
  output logic [32*NUM_REGS-1:0]   reg_q,
  output logic                     proto_err
);

  localparam int          IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [3:0]  WAIT_C = 4'(WAIT_STATES);

  // Target kind of a decoded address
  localparam logic [1:0] K_RW  = 2'd0;
  localparam logic [1:0] K_ID  = 2'd1;
  localparam logic [1:0] K_CNT = 2'd2;
  localparam logic [1:0] K_BAD = 2'd3;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  state_t            state, state_d;
  logic [3:0]        wcnt, wcnt_d;
  logic              capture, complete, proto_set;

  logic [31:0]       cap_addr;
  logic [31:0]       cap_wdata;
  logic              cap_write;
  logic              cap_err;
  logic [1:0]        cap_kind;
  logic [IDX_W-1:0]  cap_idx;

  logic [31:0]       xfer_cnt;
  logic              reg_we;

  // --------------------------------------------------------------------------
  // Address decode of the live bus (used only when a SETUP is captured)
  // --------------------------------------------------------------------------
  logic [31:0] off;
  logic [31:0] off_word;
  logic [1:0]  dec_kind;
  logic        dec_err;

  always_comb begin
    off      = paddr - BASE_ADDR;
    off_word = off >> 2;
    dec_kind = K_BAD;
    if (off_word < 32'(NUM_REGS)) begin
      dec_kind = K_RW;
    end else if (off_word == 32'(NUM_REGS)) begin
      dec_kind = K_ID;
    end else if (off_word == 32'(NUM_REGS + 1)) begin
      dec_kind = K_CNT;
    end
    // Below-base addresses wrap to huge offsets, but are rejected explicitly
    // so a wrapped offset can never alias a valid register.
    dec_err = (paddr[1:0] != 2'b00) || (paddr < BASE_ADDR) ||
              (dec_kind == K_BAD) || (pwrite && (dec_kind != K_RW));
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
      wcnt  <= 4'd0;
    end else begin
      state <= state_d;
      wcnt  <= wcnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and control strobes
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state;
    wcnt_d    = wcnt;
    capture   = 1'b0;
    complete  = 1'b0;
    proto_set = 1'b0;
    case (state)
      ST_IDLE: begin
        if (psel && !penable) begin
          capture = 1'b1;
          wcnt_d  = WAIT_C;
          state_d = ST_ACCESS;
        end else if (psel && penable) begin
          // Access phase without a preceding setup phase
          proto_set = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (!psel || !penable) begin
          // Requester abandoned the transfer: nothing is committed
          proto_set = 1'b1;
          wcnt_d    = 4'd0;
          state_d   = ST_IDLE;
        end else begin
          if ((paddr != cap_addr) || (pwrite != cap_write) || (pwdata != cap_wdata)) begin
            proto_set = 1'b1;
          end
          if (wcnt != 4'd0) begin
            wcnt_d = wcnt - 4'd1;
          end else begin
            complete = 1'b1;
            state_d  = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        wcnt_d  = 4'd0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Request capture (the captured copy is authoritative for the transfer)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cap_addr  <= 32'd0;
      cap_wdata <= 32'd0;
      cap_write <= 1'b0;
      cap_err   <= 1'b0;
      cap_kind  <= K_RW;
      cap_idx   <= '0;
    end else if (capture) begin
      cap_addr  <= paddr;
      cap_wdata <= pwdata;
      cap_write <= pwrite;
      cap_err   <= dec_err;
      cap_kind  <= dec_kind;
      cap_idx   <= off_word[IDX_W-1:0];
    end
  end

  // --------------------------------------------------------------------------
  // Transfer counter and sticky protocol flag
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      xfer_cnt  <= 32'd0;
      proto_err <= 1'b0;
    end else begin
      if (complete) begin
        xfer_cnt <= xfer_cnt + 32'd1;
      end
      if (proto_set) begin
        proto_err <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // RW registers. Writes to non-RW targets are already flagged in cap_err,
  // so an error-free write always addresses a valid RW register.
  // --------------------------------------------------------------------------
  assign reg_we = complete && cap_write && !cap_err;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    logic [31:0] q;
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        q <= 32'd0;
      end else if (reg_we && (cap_idx == IDX_W'(i))) begin
        q <= cap_wdata;
      end
    end
    assign reg_q[32*i +: 32] = q;
  end

  // --------------------------------------------------------------------------
  // Response, decoded from flops only
  // --------------------------------------------------------------------------
  assign pready  = (state == ST_ACCESS) && (wcnt == 4'd0);
  assign pslverr = pready && cap_err;

  // xfer_cnt increments on the completion edge, so a counter read sees the
  // value before this transfer is counted.
  always_comb begin
    prdata = 32'd0;
    if (pready && !cap_write && !cap_err) begin
      case (cap_kind)
        K_RW:    prdata = reg_q[{cap_idx, 5'b00000} +: 32];
        K_ID:    prdata = ID_VALUE;
        K_CNT:   prdata = xfer_cnt;
        default: prdata = 32'd0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_reg_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_reg_responder
// Purpose  : Directed self-checking bench for apb_reg_responder. Instance 0
//            runs with no wait states, instance 1 with three wait states.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_reg_responder;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] ID_A = BASE + 32'h20;
  localparam logic [31:0] CNT_A = BASE + 32'h24;

  logic        clk;
  logic        rstn;
  logic [31:0] paddr [2];
  logic [31:0] pwdata [2];
  logic        pwrite [2];
  logic        psel [2];
  logic        penable [2];
  logic [31:0] prdata [2];
  logic        pready [2];
  logic        pslverr [2];
  logic        proto_err [2];
  logic [255:0] reg_q0, reg_q1;

  int checks = 0;
  int errors = 0;

  apb_reg_responder #(
    .NUM_REGS(8), .BASE_ADDR(BASE), .WAIT_STATES(0), .ID_VALUE(32'hA5B0_0001)
  ) dut0 (
    .clk(clk), .rstn(rstn), .paddr(paddr[0]), .pwdata(pwdata[0]), .pwrite(pwrite[0]),
    .psel(psel[0]), .penable(penable[0]), .prdata(prdata[0]), .pready(pready[0]),
    .pslverr(pslverr[0]), .reg_q(reg_q0), .proto_err(proto_err[0])
  );

  apb_reg_responder #(
    .NUM_REGS(8), .BASE_ADDR(BASE), .WAIT_STATES(3), .ID_VALUE(32'hA5B0_0001)
  ) dut1 (
    .clk(clk), .rstn(rstn), .paddr(paddr[1]), .pwdata(pwdata[1]), .pwrite(pwrite[1]),
    .psel(psel[1]), .penable(penable[1]), .prdata(prdata[1]), .pready(pready[1]),
    .pslverr(pslverr[1]), .reg_q(reg_q1), .proto_err(proto_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_wide(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transfer: SETUP at a negedge, ACCESS from the next negedge,
  // returning at the negedge where pready is seen (completion edge still ahead).
  task automatic xfer(input int b, input logic [31:0] a, input logic w, input logic [31:0] d,
                      output logic [31:0] rd, output logic err, output int cyc);
    @(negedge clk);
    psel[b] = 1'b1; penable[b] = 1'b0; paddr[b] = a; pwrite[b] = w; pwdata[b] = d;
    @(negedge clk);
    penable[b] = 1'b1;
    cyc = 2;
    while (pready[b] !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (pready[b] !== 1'b1) begin
      cyc = -1;
      rd  = 32'hxxxx_xxxx;
      err = 1'bx;
    end else begin
      rd  = prdata[b];
      err = pslverr[b];
    end
  endtask

  task automatic idle(input int b);
    @(negedge clk);
    psel[b] = 1'b0; penable[b] = 1'b0;
  endtask

  logic [31:0]  rd;
  logic         err;
  int           cyc;
  logic [31:0]  cnt0, cnt1;
  logic [255:0] exp_q;

  initial begin
    rstn = 1'b0;
    for (int b = 0; b < 2; b++) begin
      paddr[b] = '0; pwdata[b] = '0; pwrite[b] = 1'b0; psel[b] = 1'b0; penable[b] = 1'b0;
    end
    cnt0 = 0; cnt1 = 0;
    repeat (3) @(negedge clk);
    chk("rst_pready", {31'd0, pready[0]}, 32'd0);
    chk("rst_prdata", prdata[0], 32'd0);
    chk("rst_pslverr", {31'd0, pslverr[0]}, 32'd0);
    chk_wide("rst_reg_q", reg_q0, 256'd0);
    chk("rst_proto", {31'd0, proto_err[0]}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // ---- instance 0, no wait states ----
    xfer(0, BASE + 32'h4, 1'b1, 32'hDEAD_BEEF, rd, err, cyc); cnt0++;
    chk("w0_cycles", cyc, 32'd2);
    chk("w0_err", {31'd0, err}, 32'd0);
    chk("w0_regq_not_yet", reg_q0[63:32], 32'd0);
    xfer(0, BASE + 32'h4, 1'b0, 32'd0, rd, err, cyc); cnt0++;
    chk("r0_cycles", cyc, 32'd2);
    chk("r0_data", rd, 32'hDEAD_BEEF);
    chk("r0_err", {31'd0, err}, 32'd0);
    chk("r0_regq", reg_q0[63:32], 32'hDEAD_BEEF);

    xfer(0, ID_A, 1'b0, 32'd0, rd, err, cyc); cnt0++;
    chk("id_read", rd, 32'hA5B0_0001);
    xfer(0, ID_A, 1'b1, 32'h1, rd, err, cyc); cnt0++;
    chk("id_write_err", {31'd0, err}, 32'd1);
    xfer(0, ID_A, 1'b0, 32'd0, rd, err, cyc); cnt0++;
    chk("id_unchanged", rd, 32'hA5B0_0001);

    xfer(0, BASE + 32'h2, 1'b0, 32'd0, rd, err, cyc); cnt0++;
    chk("misalign_err", {31'd0, err}, 32'd1);
    chk("misalign_data", rd, 32'd0);
    xfer(0, BASE + 32'h28, 1'b0, 32'd0, rd, err, cyc); cnt0++;
    chk("beyond_err", {31'd0, err}, 32'd1);
    chk("beyond_data", rd, 32'd0);
    xfer(0, BASE - 32'h4, 1'b0, 32'd0, rd, err, cyc); cnt0++;
    chk("below_err", {31'd0, err}, 32'd1);

    xfer(0, BASE + 32'h1C, 1'b1, 32'h1234_5678, rd, err, cyc); cnt0++;
    xfer(0, BASE + 32'h1C, 1'b0, 32'd0, rd, err, cyc); cnt0++;
    chk("last_reg", rd, 32'h1234_5678);
    xfer(0, CNT_A, 1'b0, 32'd0, rd, err, cyc);
    chk("cnt_read", rd, cnt0);
    chk("cnt_err", {31'd0, err}, 32'd0);
    cnt0++;
    xfer(0, CNT_A, 1'b1, 32'h5, rd, err, cyc); cnt0++;
    chk("cnt_write_err", {31'd0, err}, 32'd1);
    @(negedge clk);
    exp_q = '0;
    exp_q[63:32]   = 32'hDEAD_BEEF;
    exp_q[255:224] = 32'h1234_5678;
    chk_wide("regq_map", reg_q0, exp_q);
    chk("no_proto0", {31'd0, proto_err[0]}, 32'd0);

    // penable without setup while idle
    psel[0] = 1'b1; penable[0] = 1'b1; paddr[0] = BASE; pwrite[0] = 1'b0;
    @(negedge clk);
    chk("idle_penable_proto", {31'd0, proto_err[0]}, 32'd1);
    chk("idle_penable_pready", {31'd0, pready[0]}, 32'd0);
    psel[0] = 1'b0; penable[0] = 1'b0;

    // ---- instance 1, three wait states ----
    xfer(1, BASE + 32'h8, 1'b1, 32'hCAFE_F00D, rd, err, cyc); cnt1++;
    chk("w3_cycles", cyc, 32'd5);
    chk("w3_err", {31'd0, err}, 32'd0);
    xfer(1, BASE + 32'h8, 1'b0, 32'd0, rd, err, cyc); cnt1++;
    chk("r3_cycles", cyc, 32'd5);
    chk("r3_data", rd, 32'hCAFE_F00D);
    chk("no_proto1", {31'd0, proto_err[1]}, 32'd0);

    // abort: drop psel after one waiting ACCESS cycle
    @(negedge clk);
    psel[1] = 1'b1; penable[1] = 1'b0; paddr[1] = BASE + 32'hC; pwrite[1] = 1'b1; pwdata[1] = 32'h55;
    @(negedge clk);
    penable[1] = 1'b1;
    @(negedge clk);
    chk("abort_pready_low", {31'd0, pready[1]}, 32'd0);
    psel[1] = 1'b0; penable[1] = 1'b0;
    @(negedge clk);
    chk("abort_proto", {31'd0, proto_err[1]}, 32'd1);
    chk("abort_no_write", reg_q1[127:96], 32'd0);
    xfer(1, BASE + 32'hC, 1'b0, 32'd0, rd, err, cyc); cnt1++;
    chk("abort_readback", rd, 32'd0);
    xfer(1, CNT_A, 1'b0, 32'd0, rd, err, cyc);
    chk("abort_no_count", rd, cnt1);
    idle(1);

    // asynchronous reset in the middle of a waiting write
    @(negedge clk);
    psel[1] = 1'b1; penable[1] = 1'b0; paddr[1] = BASE + 32'h10; pwrite[1] = 1'b1; pwdata[1] = 32'h77;
    @(negedge clk);
    penable[1] = 1'b1;
    @(negedge clk);
    chk("pre_rst_regq", reg_q1[95:64], 32'hCAFE_F00D);
    #2 rstn = 1'b0;
    #1;
    chk("arst_pready", {31'd0, pready[1]}, 32'd0);
    chk_wide("arst_regq1", reg_q1, 256'd0);
    chk_wide("arst_regq0", reg_q0, 256'd0);
    chk("arst_proto1", {31'd0, proto_err[1]}, 32'd0);
    chk("arst_proto0", {31'd0, proto_err[0]}, 32'd0);
    @(negedge clk);
    psel[1] = 1'b0; penable[1] = 1'b0;
    rstn = 1'b1;
    xfer(1, BASE + 32'h10, 1'b0, 32'd0, rd, err, cyc);
    chk("arst_write_lost", rd, 32'd0);
    idle(1);

    // counter wrap on instance 0
    @(negedge clk);
    force dut0.xfer_cnt = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut0.xfer_cnt;
    xfer(0, CNT_A, 1'b0, 32'd0, rd, err, cyc);
    chk("cnt_max", rd, 32'hFFFF_FFFF);
    xfer(0, CNT_A, 1'b0, 32'd0, rd, err, cyc);
    chk("cnt_wrap", rd, 32'd0);
    idle(0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
